uart_rx_fifo: RTL and testbench

//  Parametrised UART receive path: 2-flop RX synchroniser, mid-bit sampling FSM,

---
 rtl/uart_rx_fifo_if.sv | 21 ++
 rtl/uart_rx_fifo.sv | 247 ++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Show-ahead pop port of the UART receive FIFO.
// The master side (the receiver) presents the head entry; the slave side accepts it.
interface uart_rx_fifo_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 rd_valid;
  logic                 rd_ready;
  logic [DATA_BITS-1:0] rd_data;

  modport master (
    output rd_valid,
    output rd_data,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    output rd_ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with a 2-flop synchroniser and a mid-bit sampling FSM.
// Good frames are pushed into a circular FIFO with a valid/ready pop port.
module uart_rx_fifo #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned PARITY_MODE  = 1,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx,
  input  logic                        ovf_clr,
  uart_rx_fifo_if.master              rd,
  output logic [$clog2(FIFO_DEPTH):0] fill_level,
  output logic                        overflow,
  output logic                        parity_err,
  output logic                        frame_err,
  output logic                        busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  localparam logic [CntW-1:0] HalfCnt  = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] LastCnt  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(DATA_BITS - 1);
  localparam logic            LastStop = 1'(STOP_BITS - 1);
  localparam logic [LvlW-1:0] FullLvl  = LvlW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // Synchroniser
  logic rx_q1, rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rx_s  <= rx_q1;
    end
  end

  // Receive FSM
  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 bad_par_q, bad_par_d;
  logic                 bad_stop_q, bad_stop_d;
  logic                 frame_done;
  logic                 exp_par;
  logic                 stop_bad;
  logic                 push;

  assign exp_par = (PARITY_MODE == 2) ? ~^shift_q : ^shift_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    bad_par_d  = bad_par_q;
    bad_stop_d = bad_stop_q;
    frame_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end

      StStart: begin
        if (cnt_q == HalfCnt) begin
          if (rx_s) begin
            // Start bit gone high by mid-bit: a glitch, not a frame.
            state_d = StIdle;
          end else begin
            state_d    = StData;
            cnt_d      = '0;
            idx_d      = '0;
            stop_idx_d = 1'b0;
            bad_par_d  = 1'b0;
            bad_stop_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StData: begin
        if (cnt_q == LastCnt) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == LastIdx) begin
            state_d = (PARITY_MODE != 0) ? StParity : StStop;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StParity: begin
        if (cnt_q == LastCnt) begin
          cnt_d     = '0;
          bad_par_d = (rx_s != exp_par);
          state_d   = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StStop: begin
        if (cnt_q == LastCnt) begin
          cnt_d = '0;
          if (!rx_s) begin
            bad_stop_d = 1'b1;
          end
          // Return to idle at mid-stop so a fast sender's next start is caught.
          if (stop_idx_q == LastStop) begin
            frame_done = 1'b1;
            state_d    = StIdle;
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      bad_par_q  <= 1'b0;
      bad_stop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      bad_par_q  <= bad_par_d;
      bad_stop_q <= bad_stop_d;
    end
  end

  // The final stop sample is folded in directly since bad_stop_q has not yet seen it.
  assign stop_bad = bad_stop_q | ~rx_s;
  assign push     = frame_done & ~stop_bad & ~bad_par_q;

  logic parity_err_q, frame_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      frame_err_q  <= frame_done & stop_bad;
      parity_err_q <= frame_done & ~stop_bad & bad_par_q;
    end
  end

  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != StIdle);

  // FIFO
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]      count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 pop, full, wr_en, ovf_set;

  always_comb begin
    pop     = (count_q != '0) & rd.rd_ready;
    full    = (count_q == FullLvl);
    wr_en   = push & (~full | pop);
    ovf_set = push & full & ~pop;

    count_d = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!wr_en && pop) begin
      count_d = count_q - 1'b1;
    end

    // A set in the same cycle as a clear wins.
    overflow_d = overflow_q;
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign rd.rd_valid = (count_q != '0);
  assign rd.rd_data  = mem_q[rd_ptr_q];
  assign fill_level  = count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: u0 is 8-bit/even/1-stop, u1 is 7-bit/odd/2-stop, both 16 clks per bit.
module tb_uart_rx_fifo;
  localparam int unsigned Clks = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;
  logic ovf_clr0 = 1'b0;
  logic ovf_clr1 = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_BITS(8)) rd0 ();
  uart_rx_fifo_if #(.DATA_BITS(7)) rd1 ();

  logic [2:0] fill0, fill1;
  logic       ovf0, perr0, ferr0, busy0;
  logic       ovf1, perr1, ferr1, busy1;

  uart_rx_fifo #(
    .DATA_BITS(8), .CLKS_PER_BIT(Clks), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .ovf_clr(ovf_clr0), .rd(rd0.master),
    .fill_level(fill0), .overflow(ovf0), .parity_err(perr0), .frame_err(ferr0), .busy(busy0)
  );

  uart_rx_fifo #(
    .DATA_BITS(7), .CLKS_PER_BIT(Clks), .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .ovf_clr(ovf_clr1), .rd(rd1.master),
    .fill_level(fill1), .overflow(ovf1), .parity_err(perr1), .frame_err(ferr1), .busy(busy1)
  );

  // Pulse counters; tests compare deltas across a frame.
  int perr_n0 = 0, ferr_n0 = 0, perr_n1 = 0, ferr_n1 = 0;
  always @(posedge clk) begin
    if (perr0) perr_n0 <= perr_n0 + 1;
    if (ferr0) ferr_n0 <= ferr_n0 + 1;
    if (perr1) perr_n1 <= perr_n1 + 1;
    if (ferr1) ferr_n1 <= ferr_n1 + 1;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Line bits LSB first: start, data, parity, stop
  function automatic logic [15:0] frame8(input logic [7:0] d, input logic p, input logic s);
    return {5'b0, s, p, d, 1'b0};
  endfunction

  function automatic logic [15:0] frame7(input logic [6:0] d, input logic p, input logic s1,
                                         input logic s2);
    return {5'b0, s2, s1, p, d, 1'b0};
  endfunction

  task automatic drive(input int which, input logic v);
    if (which == 0) rx0 = v;
    else rx1 = v;
  endtask

  task automatic set_ready(input int which, input logic v);
    if (which == 0) rd0.rd_ready = v;
    else rd1.rd_ready = v;
  endtask

  // Last-bit sample reads the line 8 negedges into the bit and completes on the 11th
  // posedge; a low final stop is held only through that sample so no false start follows.
  task automatic send(input int which, input logic [15:0] bits, input int n,
                      input bit pop_at_done);
    for (int i = 0; i < n; i++) begin
      drive(which, bits[i]);
      if (i == n - 1 && bits[i] == 1'b0) begin
        repeat (9) @(negedge clk);
        drive(which, 1'b1);
        repeat (7) @(negedge clk);
      end else if (i == n - 1 && pop_at_done) begin
        repeat (10) @(negedge clk);
        set_ready(which, 1'b1);
        @(negedge clk);
        set_ready(which, 1'b0);
        repeat (5) @(negedge clk);
      end else begin
        repeat (Clks) @(negedge clk);
      end
    end
    drive(which, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic pop0();
    rd0.rd_ready = 1'b1;
    @(negedge clk);
    rd0.rd_ready = 1'b0;
  endtask

  task automatic pop1();
    rd1.rd_ready = 1'b1;
    @(negedge clk);
    rd1.rd_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_perr;
    int         exp_ferr;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int p0, f0;
    logic [15:0] fr;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 0, 0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b0, 8'h00, 1, 0};
    vecs[2] = '{8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 0, 0};
    vecs[3] = '{8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1};
    vecs[4] = '{8'h55, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1};
    vecs[5] = '{8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 0, 0};
    vecs[6] = '{8'h80, 1'b1, 1'b1, 1'b1, 8'h80, 0, 0};
    vecs[7] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 0, 0};
    vecs[8] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 1, 0};

    rd0.rd_ready = 1'b0;
    rd1.rd_ready = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_valid", 32'(rd0.rd_valid), 32'd0);
    check("rst_data", 32'(rd0.rd_data), 32'd0);
    check("rst_fill", 32'(fill0), 32'd0);
    check("rst_ovf", 32'(ovf0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_errs", 32'({perr0, ferr0}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frames through u0
    for (int i = 0; i < 9; i++) begin
      p0 = perr_n0;
      f0 = ferr_n0;
      send(0, frame8(vecs[i].data, vecs[i].par, vecs[i].stop), 11, 1'b0);
      check($sformatf("vec%0d_valid", i), 32'(rd0.rd_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_fill", i), 32'(fill0), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_perr", i), 32'(perr_n0 - p0), 32'(vecs[i].exp_perr));
      check($sformatf("vec%0d_ferr", i), 32'(ferr_n0 - f0), 32'(vecs[i].exp_ferr));
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_data", i), 32'(rd0.rd_data), 32'(vecs[i].exp_data));
        pop0();
        check($sformatf("vec%0d_popfill", i), 32'(fill0), 32'd0);
      end
    end

    // Start glitch shorter than half a bit
    rx0 = 1'b0;
    repeat (4) @(negedge clk);
    rx0 = 1'b1;
    check("glitch_busy", 32'(busy0), 32'd1);
    repeat (20) @(negedge clk);
    check("glitch_idle", 32'(busy0), 32'd0);
    check("glitch_fill", 32'(fill0), 32'd0);

    // Fill and overflow
    for (int d = 1; d <= 5; d++) begin
      send(0, frame8(8'(d), ^(8'(d)), 1'b1), 11, 1'b0);
      if (d == 4) begin
        check("full_fill", 32'(fill0), 32'd4);
        check("full_noovf", 32'(ovf0), 32'd0);
      end
    end
    check("ovf_fill", 32'(fill0), 32'd4);
    check("ovf_set", 32'(ovf0), 32'd1);
    for (int d = 1; d <= 4; d++) begin
      check($sformatf("ovf_pop%0d", d), 32'(rd0.rd_data), 32'(d));
      pop0();
    end
    check("ovf_empty", 32'(rd0.rd_valid), 32'd0);
    check("ovf_sticky", 32'(ovf0), 32'd1);
    ovf_clr0 = 1'b1;
    @(negedge clk);
    ovf_clr0 = 1'b0;
    check("ovf_clr", 32'(ovf0), 32'd0);

    // Push into a full FIFO on the same edge as a pop
    for (int d = 'h10; d <= 'h13; d++) begin
      send(0, frame8(8'(d), ^(8'(d)), 1'b1), 11, 1'b0);
    end
    send(0, frame8(8'h14, ^(8'h14), 1'b1), 11, 1'b1);
    check("pp_fill", 32'(fill0), 32'd4);
    check("pp_noovf", 32'(ovf0), 32'd0);
    for (int d = 'h11; d <= 'h14; d++) begin
      check($sformatf("pp_pop%0h", d), 32'(rd0.rd_data), 32'(d));
      pop0();
    end
    check("pp_empty", 32'(fill0), 32'd0);

    // Reset mid-frame with entries queued
    send(0, frame8(8'h11, 1'b0, 1'b1), 11, 1'b0);
    send(0, frame8(8'h22, 1'b0, 1'b1), 11, 1'b0);
    check("mid_fill", 32'(fill0), 32'd2);
    fr = frame8(8'h7E, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      rx0 = fr[i];
      repeat (Clks) @(negedge clk);
    end
    check("mid_busy", 32'(busy0), 32'd1);
    rst_n = 1'b0;
    rx0   = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_valid", 32'(rd0.rd_valid), 32'd0);
    check("mid_rst_data", 32'(rd0.rd_data), 32'd0);
    check("mid_rst_fill", 32'(fill0), 32'd0);
    check("mid_rst_busy", 32'(busy0), 32'd0);
    check("mid_rst_flags", 32'({ovf0, perr0, ferr0}), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send(0, frame8(8'h7E, 1'b0, 1'b1), 11, 1'b0);
    check("post_rst_fill", 32'(fill0), 32'd1);
    check("post_rst_data", 32'(rd0.rd_data), 32'h7E);
    pop0();

    // u1: 7 data bits, odd parity, two stop bits
    p0 = perr_n1;
    f0 = ferr_n1;
    send(1, frame7(7'h25, 1'b0, 1'b1, 1'b1), 11, 1'b0);
    check("u1_valid", 32'(rd1.rd_valid), 32'd1);
    check("u1_data", 32'(rd1.rd_data), 32'h25);
    check("u1_fill", 32'(fill1), 32'd1);
    check("u1_noerr", 32'((perr_n1 - p0) + (ferr_n1 - f0)), 32'd0);
    pop1();
    check("u1_pop", 32'(fill1), 32'd0);

    p0 = perr_n1;
    send(1, frame7(7'h25, 1'b1, 1'b1, 1'b1), 11, 1'b0);
    check("u1_perr", 32'(perr_n1 - p0), 32'd1);
    check("u1_perr_fill", 32'(fill1), 32'd0);

    f0 = ferr_n1;
    send(1, frame7(7'h25, 1'b0, 1'b1, 1'b0), 11, 1'b0);
    check("u1_ferr_stop2", 32'(ferr_n1 - f0), 32'd1);

    f0 = ferr_n1;
    send(1, frame7(7'h25, 1'b0, 1'b0, 1'b1), 11, 1'b0);
    check("u1_ferr_stop1", 32'(ferr_n1 - f0), 32'd1);
    check("u1_ferr_fill", 32'(fill1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
